rtc_reg_bank: RTL and testbench

Parametrised capture-and-replay register bank between the RTC bus read sequencer and the VGA text renderer. Captures one data byte per read transaction into a shadow bank during a programmable window of the sequencer step counter. On frame completion, commits the frame atomically to an output bank. Replays the committed bank as a time-multiplexed byte stream with a sync marker.

---
 rtl/rtc_reg_pkg.sv | 18 +
 rtl/rtc_reg_bank_if.sv | 21 ++
 rtl/rtc_reg_serializer.sv | 71 +++++++
 rtl/rtc_reg_bank.sv | 155 +++++++++++++++
 tb/tb_rtc_reg_bank.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_reg_pkg.sv
// Shared types and constants for the RTC capture-and-replay register bank.
package rtc_reg_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   localparam logic [7:0] WIN_LO_DEF  = 8'h18;
   localparam logic [7:0] WIN_HI_DEF  = 8'h1E;
   localparam logic [7:0] ARM_MIN_DEF = 8'd37;

   // Index width able to hold 0..n (the serializer's marker slot needs n itself).
   function automatic int idx_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rtc_reg_bank_if.sv
// Sequencer-side bus feeding the register bank: read data, step counter and control strobes.
interface rtc_reg_bank_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) ();

   logic [DATA_W-1:0] data_i;
   logic [CNT_W-1:0]  seq_cnt_i;
   logic              rd_i;
   logic              enable_i;
   logic              abort_i;

   modport master (
      output data_i, seq_cnt_i, rd_i, enable_i, abort_i
   );

   modport slave (
      input data_i, seq_cnt_i, rd_i, enable_i, abort_i
   );

endinterface

// File: rtl/rtc_reg_serializer.sv
// Replays the committed bank as a time-multiplexed byte stream: slots 0..NUM_REGS-1
// carry the registers, slot NUM_REGS is a zero byte flagged as the sync marker.
module rtc_reg_serializer
   import rtc_reg_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NUM_REGS  = 11,
   parameter int SLOT_CLKS = 1,
   parameter int IDX_W     = idx_width(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REGS*DATA_W-1:0]   bank,
   output logic [DATA_W-1:0]            ser_data_o,
   output logic [IDX_W-1:0]             ser_slot_o,
   output logic                         ser_sync_o
);

   localparam int PRE_W = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SLOT_CLKS - 1);
   localparam logic [IDX_W-1:0] SLOT_LAST = IDX_W'(NUM_REGS);

   logic [PRE_W-1:0]  pre_r;
   logic [IDX_W-1:0]  slot_r;
   logic              slot_adv_s;
   logic [DATA_W-1:0] mux_s;
   logic              sync_s;

   assign slot_adv_s = (pre_r == PRE_LAST);

   // Prescaler and slot counter; the slot wraps from the marker back to register 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_r  <= {PRE_W{1'b0}};
         slot_r <= {IDX_W{1'b0}};
      end else if (slot_adv_s) begin
         pre_r  <= {PRE_W{1'b0}};
         slot_r <= (slot_r == SLOT_LAST) ? {IDX_W{1'b0}} : slot_r + IDX_W'(1'b1);
      end else begin
         pre_r  <= pre_r + PRE_W'(1'b1);
         slot_r <= slot_r;
      end
   end

   // The marker slot matches no register, so it falls through to a zero byte.
   always_comb begin
      mux_s  = {DATA_W{1'b0}};
      sync_s = (slot_r == SLOT_LAST);
      for (int k = 0; k < NUM_REGS; k++) begin
         if (slot_r == IDX_W'(k)) begin
            mux_s = bank[k*DATA_W +: DATA_W];
         end else begin
            mux_s = mux_s;
         end
      end
   end

   // Registered replay outputs, one cycle behind the slot counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ser_data_o <= {DATA_W{1'b0}};
         ser_slot_o <= {IDX_W{1'b0}};
         ser_sync_o <= 1'b0;
      end else begin
         ser_data_o <= mux_s;
         ser_slot_o <= slot_r;
         ser_sync_o <= sync_s;
      end
   end

endmodule

// File: rtl/rtc_reg_bank.sv
// Captures one byte per qualified read into a shadow bank, commits whole frames
// atomically to the output bank, and hands the committed bank to the serializer.
module rtc_reg_bank
   import rtc_reg_pkg::*;
#(
   parameter int               DATA_W    = 8,
   parameter int               NUM_REGS  = 11,
   parameter int               CNT_W     = 8,
   parameter logic [CNT_W-1:0] WIN_LO    = WIN_LO_DEF,
   parameter logic [CNT_W-1:0] WIN_HI    = WIN_HI_DEF,
   parameter logic [CNT_W-1:0] ARM_MIN   = ARM_MIN_DEF,
   parameter int               SLOT_CLKS = 1,
   localparam int              IDX_W     = idx_width(NUM_REGS)
) (
   input  logic                        clk,
   input  logic                        reset,
   rtc_reg_bank_if.slave               bus,
   output logic [IDX_W-1:0]            wr_idx_o,
   output logic                        filling_o,
   output logic                        frame_done_o,
   output logic [NUM_REGS*DATA_W-1:0]  regs_o,
   output logic [DATA_W-1:0]           ser_data_o,
   output logic [IDX_W-1:0]            ser_slot_o,
   output logic                        ser_sync_o
);

   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   logic                       rd_q_r;
   logic                       qe_s;
   logic                       in_win_s;
   logic                       capture_s;
   logic                       commit_s;
   state_t                     state_r;
   state_t                     state_nx_s;
   logic [IDX_W-1:0]           wr_idx_r;
   logic [IDX_W-1:0]           wr_idx_nx_s;
   logic                       frame_done_r;
   logic [DATA_W-1:0]          shadow_r [NUM_REGS];
   logic [NUM_REGS*DATA_W-1:0] bank_r;

   assign qe_s      = rd_q_r & ~bus.rd_i & bus.enable_i & (bus.seq_cnt_i > ARM_MIN);
   assign in_win_s  = (bus.seq_cnt_i >= WIN_LO) && (bus.seq_cnt_i <= WIN_HI);
   // Abort leaves the shadow untouched, even on an in-window cycle.
   assign capture_s = (state_r == FILL) && in_win_s && !bus.abort_i;

   // Read-strobe delay for falling-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q_r <= 1'b0;
      end else begin
         rd_q_r <= bus.rd_i;
      end
   end

   // FSM state register together with the write index and commit pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         wr_idx_r     <= IDX_ZERO;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         wr_idx_r     <= wr_idx_nx_s;
         frame_done_r <= commit_s;
      end
   end

   // Next state: abort beats any simultaneous qualified edge.
   always_comb begin
      state_nx_s  = state_r;
      wr_idx_nx_s = wr_idx_r;
      commit_s    = 1'b0;
      if (bus.abort_i) begin
         state_nx_s  = IDLE;
         wr_idx_nx_s = IDX_ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (qe_s) begin
                  state_nx_s  = FILL;
                  wr_idx_nx_s = IDX_ZERO;
               end else begin
                  state_nx_s  = IDLE;
               end
            end
            FILL: begin
               if (qe_s && (wr_idx_r == LAST_IDX)) begin
                  state_nx_s  = IDLE;
                  wr_idx_nx_s = IDX_ZERO;
                  commit_s    = 1'b1;
               end else if (qe_s) begin
                  wr_idx_nx_s = wr_idx_r + IDX_W'(1'b1);
               end else begin
                  state_nx_s  = FILL;
               end
            end
            default: begin
               state_nx_s  = IDLE;
               wr_idx_nx_s = IDX_ZERO;
            end
         endcase
      end
   end

   // Output decode from registered state.
   always_comb begin
      filling_o    = (state_r == FILL);
      wr_idx_o     = wr_idx_r;
      frame_done_o = frame_done_r;
      regs_o       = bank_r;
   end

   // Shadow capture: every in-window cycle overwrites, so the last one wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            shadow_r[k] <= {DATA_W{1'b0}};
         end
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (capture_s && (wr_idx_r == IDX_W'(k))) begin
               shadow_r[k] <= bus.data_i;
            end
         end
      end
   end

   // Atomic commit of the whole shadow into the output bank.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bank_r <= {(NUM_REGS*DATA_W){1'b0}};
      end else if (commit_s) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            bank_r[k*DATA_W +: DATA_W] <= shadow_r[k];
         end
      end
   end

   rtc_reg_serializer #(
      .DATA_W    (DATA_W),
      .NUM_REGS  (NUM_REGS),
      .SLOT_CLKS (SLOT_CLKS),
      .IDX_W     (IDX_W)
   ) u_ser (
      .clk        (clk),
      .reset      (reset),
      .bank       (bank_r),
      .ser_data_o (ser_data_o),
      .ser_slot_o (ser_slot_o),
      .ser_sync_o (ser_sync_o)
   );

endmodule

// File: tb/tb_rtc_reg_bank.sv
// Directed-plus-random bench for rtc_reg_bank against a frame-level reference model.
module tb_rtc_reg_bank;

   localparam int DATA_W    = 8;
   localparam int NUM_REGS  = 11;
   localparam int CNT_W     = 8;
   localparam int SLOT_CLKS = 3;
   localparam int IDX_W     = 4;
   localparam int PERIOD    = (NUM_REGS + 1) * SLOT_CLKS;

   logic                        clk = 1'b0;
   logic                        reset;
   logic [IDX_W-1:0]            wr_idx_o;
   logic                        filling_o;
   logic                        frame_done_o;
   logic [NUM_REGS*DATA_W-1:0]  regs_o;
   logic [DATA_W-1:0]           ser_data_o;
   logic [IDX_W-1:0]            ser_slot_o;
   logic                        ser_sync_o;

   always #5 clk = ~clk;

   rtc_reg_bank_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   rtc_reg_bank #(
      .DATA_W    (DATA_W),
      .NUM_REGS  (NUM_REGS),
      .CNT_W     (CNT_W),
      .WIN_LO    (8'h18),
      .WIN_HI    (8'h1E),
      .ARM_MIN   (8'd37),
      .SLOT_CLKS (SLOT_CLKS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .wr_idx_o     (wr_idx_o),
      .filling_o    (filling_o),
      .frame_done_o (frame_done_o),
      .regs_o       (regs_o),
      .ser_data_o   (ser_data_o),
      .ser_slot_o   (ser_slot_o),
      .ser_sync_o   (ser_sync_o)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model state: frame-level view of the bank plus the replay schedule.
   logic [7:0] m_shadow [NUM_REGS];
   logic [7:0] m_bank   [NUM_REGS];
   bit         m_fill;
   int         m_idx;
   bit         m_rd_prev;
   bit         m_done;
   int         edges;
   int         exp_slot;
   logic [7:0] exp_ser;
   bit         exp_sync;
   int         dut_done;
   logic [7:0] saved [NUM_REGS];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_REGS*DATA_W-1:0] packed_bank();
      logic [NUM_REGS*DATA_W-1:0] v;
      for (int k = 0; k < NUM_REGS; k++) v[k*DATA_W +: DATA_W] = m_bank[k];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NUM_REGS; k++) begin
         m_shadow[k] = 8'h00;
         m_bank[k]   = 8'h00;
      end
      m_fill = 0; m_idx = 0; m_rd_prev = 0; m_done = 0; edges = 0;
      exp_slot = 0; exp_ser = 8'h00; exp_sync = 0;
   endtask

   task automatic check_all();
      check("wr_idx", wr_idx_o, m_idx);
      check("filling", filling_o, m_fill);
      check("frame_done", frame_done_o, m_done);
      check("regs", regs_o, packed_bank());
      check("ser_data", ser_data_o, exp_ser);
      check("ser_slot", ser_slot_o, exp_slot);
      check("ser_sync", ser_sync_o, exp_sync);
   endtask

   // One clock: advance the model from the current inputs, then compare after the edge.
   task automatic cyc();
      bit fall, qe, cap;
      int cur, ps;
      fall = m_rd_prev && !bus.rd_i;
      qe   = fall && bus.enable_i && (bus.seq_cnt_i > 8'd37);
      cap  = m_fill && (bus.seq_cnt_i >= 8'h18) && (bus.seq_cnt_i <= 8'h1E) && !bus.abort_i;
      cur  = m_idx;
      ps   = (edges / SLOT_CLKS) % (NUM_REGS + 1);
      exp_slot = ps;
      exp_sync = (ps == NUM_REGS);
      exp_ser  = exp_sync ? 8'h00 : m_bank[ps];
      m_done   = 0;
      if (bus.abort_i) begin
         m_fill = 0; m_idx = 0;
      end else if (!m_fill) begin
         if (qe) begin m_fill = 1; m_idx = 0; end
      end else if (qe) begin
         if (m_idx == NUM_REGS - 1) begin
            for (int k = 0; k < NUM_REGS; k++) m_bank[k] = m_shadow[k];
            m_done = 1; m_fill = 0; m_idx = 0;
         end else begin
            m_idx++;
         end
      end
      if (cap) m_shadow[cur] = bus.data_i;
      m_rd_prev = bus.rd_i;
      edges++;
      @(posedge clk);
      #1;
      if (frame_done_o) dut_done++;
      check_all();
   endtask

   task automatic qedge(input logic [7:0] cnt, input logic en, input logic ab);
      bus.rd_i = 1'b1; bus.seq_cnt_i = 8'h30; bus.abort_i = 1'b0; bus.enable_i = 1'b1;
      cyc();
      bus.rd_i = 1'b0; bus.seq_cnt_i = cnt; bus.enable_i = en; bus.abort_i = ab;
      cyc();
      bus.abort_i = 1'b0; bus.enable_i = 1'b1; bus.seq_cnt_i = 8'h30;
   endtask

   // Out-of-window noise, then the full window with the chosen byte landing last.
   task automatic sweep(input logic [7:0] last, input bit noisy);
      bus.seq_cnt_i = 8'h10; bus.data_i = 8'($urandom); cyc();
      for (int c = 8'h18; c <= 8'h1E; c++) begin
         bus.seq_cnt_i = 8'(c);
         bus.data_i    = (noisy && c != 8'h1E) ? 8'($urandom) : last;
         cyc();
      end
      bus.seq_cnt_i = 8'h30; bus.data_i = 8'($urandom); cyc();
   endtask

   initial begin
      bus.data_i = 8'h00; bus.seq_cnt_i = 8'h00; bus.rd_i = 1'b0;
      bus.enable_i = 1'b1; bus.abort_i = 1'b0;
      dut_done = 0;
      reset = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;

      // Full frame with 0xA0+k in register k
      qedge(8'd38, 1'b1, 1'b0);
      for (int k = 0; k < NUM_REGS; k++) begin
         sweep(8'(8'hA0 + k), 1'b0);
         qedge(8'd38, 1'b1, 1'b0);
      end
      check("full_done_pulse", frame_done_o, 1'b1);
      for (int k = 0; k < NUM_REGS; k++) check("full_reg", regs_o[k*DATA_W +: DATA_W], 8'hA0 + k);
      cyc();
      check("full_done_once", dut_done, 1);

      // Qualification boundary and enable gating
      qedge(8'd37, 1'b1, 1'b0);
      check("qual_37_fill", filling_o, 1'b0);
      qedge(8'd38, 1'b0, 1'b0);
      check("qual_dis_fill", filling_o, 1'b0);
      check("qual_dis_idx", wr_idx_o, 0);
      qedge(8'd38, 1'b1, 1'b0);
      check("qual_38_fill", filling_o, 1'b1);

      // Window bounds on register 0, remainder random
      bus.seq_cnt_i = 8'h17; bus.data_i = 8'h55; cyc();
      bus.seq_cnt_i = 8'h18; bus.data_i = 8'h11; cyc();
      bus.seq_cnt_i = 8'h1E; bus.data_i = 8'h22; cyc();
      bus.seq_cnt_i = 8'h1F; bus.data_i = 8'h77; cyc();
      qedge(8'd38, 1'b1, 1'b0);
      for (int k = 1; k < NUM_REGS; k++) begin
         sweep(8'($urandom), 1'b1);
         qedge(8'($urandom_range(38, 255)), 1'b1, 1'b0);
      end
      check("win_reg0", regs_o[7:0], 8'h22);

      // Abort after five registers keeps the committed frame
      for (int k = 0; k < NUM_REGS; k++) saved[k] = regs_o[k*DATA_W +: DATA_W];
      dut_done = 0;
      qedge(8'd40, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         sweep(8'($urandom), 1'b1);
         qedge(8'd38, 1'b1, 1'b0);
      end
      bus.abort_i = 1'b1; bus.seq_cnt_i = 8'h40; cyc();
      bus.abort_i = 1'b0;
      check("abort_idx", wr_idx_o, 0);
      check("abort_fill", filling_o, 1'b0);
      check("abort_no_done", dut_done, 0);
      for (int k = 0; k < NUM_REGS; k++) check("abort_regs", regs_o[k*DATA_W +: DATA_W], saved[k]);
      qedge(8'd38, 1'b1, 1'b1);
      check("abort_qe_idle", filling_o, 1'b0);
      qedge(8'd38, 1'b1, 1'b0);
      qedge(8'd38, 1'b1, 1'b1);
      check("abort_qe_fill", filling_o, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         bus.rd_i      = 1'($urandom);
         bus.enable_i  = ($urandom_range(0, 7) != 0);
         bus.abort_i   = ($urandom_range(0, 63) == 0);
         bus.data_i    = 8'($urandom);
         bus.seq_cnt_i = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(8'h16, 8'h20))
                                                     : 8'($urandom_range(30, 60));
         cyc();
      end
      bus.rd_i = 1'b0; bus.enable_i = 1'b1; bus.abort_i = 1'b0; bus.seq_cnt_i = 8'h30;
      cyc();
      bus.abort_i = 1'b1; cyc(); bus.abort_i = 1'b0;

      // Commit lands mid slot 4; slot 5 must carry the new frame
      for (int k = 0; k < NUM_REGS; k++) saved[k] = regs_o[k*DATA_W +: DATA_W] ^ 8'hFF;
      qedge(8'd38, 1'b1, 1'b0);
      for (int k = 0; k < NUM_REGS - 1; k++) begin
         sweep(saved[k], 1'b1);
         qedge(8'd38, 1'b1, 1'b0);
      end
      sweep(saved[NUM_REGS-1], 1'b1);
      for (int i = 0; i < PERIOD && (edges % PERIOD) != 12; i++) cyc();
      qedge(8'd38, 1'b1, 1'b0);
      check("commit_done", frame_done_o, 1'b1);
      for (int i = 0; i < 20 && ser_slot_o != 4'd5; i++) cyc();
      check("slot5_reached", ser_slot_o, 4'd5);
      check("slot5_new", ser_data_o, saved[5]);
      repeat (PERIOD + 2) cyc();

      // Asynchronous reset in the middle of a frame
      qedge(8'd38, 1'b1, 1'b0);
      sweep(8'($urandom), 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("rst_fill", filling_o, 1'b0);
      check("rst_idx", wr_idx_o, 0);
      check("rst_regs", regs_o, 88'h0);
      check("rst_ser", {ser_data_o, ser_slot_o, ser_sync_o, frame_done_o}, 14'h0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (PERIOD + 3) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
